universal_shift_register: RTL and testbench

Parametrised bidirectional shift register with hold, logical/arithmetic shift, rotate and parallel load. It adds a counted burst mode that shifts a programmed number of positions autonomously and reports busy/done. It sits wherever the design needs serial-to-parallel or parallel-to-serial conversion or a multi-cycle shift, and supersedes the fixed 4-bit left/right shifter.

---
 rtl/usr_pkg.sv | 27 ++
 rtl/usr_shift_core.sv | 30 +++
 rtl/universal_shift_register.sv | 103 ++++++++++
 tb/tb_universal_shift_register.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register.
// Mode encodings, FSM states and a shift-mode helper.
package usr_pkg;

    typedef enum logic [2:0] {
        M_HOLD = 3'd0,
        M_SHR  = 3'd1,
        M_SHL  = 3'd2,
        M_LOAD = 3'd3,
        M_ROR  = 3'd4,
        M_ROL  = 3'd5,
        M_ASR  = 3'd6,
        M_RSVD = 3'd7
    } usr_mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } usr_state_e;

    // Modes that move bits and may therefore be repeated as a burst.
    function automatic logic is_shift_mode(input usr_mode_e m);
        return (m == M_SHR) || (m == M_SHL) || (m == M_ROR) ||
               (m == M_ROL) || (m == M_ASR);
    endfunction

endpackage

// File: rtl/usr_shift_core.sv
// Next-state datapath of the shift register.
// Pure combinational; used by single steps and bursts alike.
module usr_shift_core
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  usr_mode_e        mode,
    input  logic             din_msb,
    input  logic             din_lsb,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] nxt
);

    // Select the next register value for the requested operation.
    always_comb begin
        nxt = q;
        case (mode)
            M_SHR:   nxt = {din_msb, q[WIDTH-1:1]};
            M_SHL:   nxt = {q[WIDTH-2:0], din_lsb};
            M_LOAD:  nxt = par_in;
            M_ROR:   nxt = {q[0], q[WIDTH-1:1]};
            M_ROL:   nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            M_ASR:   nxt = {q[WIDTH-1], q[WIDTH-1:1]};
            default: nxt = q;
        endcase
    end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register with counted burst mode.
// Holds the data register, the IDLE/BURST FSM and the down-counter.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             din_msb,
    input  logic             din_lsb,
    input  logic [WIDTH-1:0] par_in,
    input  logic             burst_start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] q,
    output logic             q_msb,
    output logic             q_lsb,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(WIDTH);

    usr_state_e       state;
    usr_mode_e        bmode;
    usr_mode_e        mode_in;
    usr_mode_e        core_mode;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_c;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;

    assign mode_in = usr_mode_e'(mode);

    // Burst lengths beyond the register width saturate at the width.
    assign len_c = (burst_len > MAX_LEN) ? MAX_LEN : burst_len;

    // A running burst uses its captured mode, never the live input.
    assign core_mode = (state == BURST) ? bmode : mode_in;

    usr_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .q       (q_r),
        .mode    (core_mode),
        .din_msb (din_msb),
        .din_lsb (din_lsb),
        .par_in  (par_in),
        .nxt     (q_nxt)
    );

    // Register, FSM and burst counter; done is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r   <= '0;
            state <= IDLE;
            bmode <= M_HOLD;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        if (burst_start && is_shift_mode(mode_in)) begin
                            if (len_c == '0) begin
                                done <= 1'b1;
                            end else begin
                                state <= BURST;
                                bmode <= mode_in;
                                cnt   <= len_c;
                                busy  <= 1'b1;
                            end
                        end else begin
                            q_r <= q_nxt;
                        end
                    end
                end
                BURST: begin
                    if (en) begin
                        q_r <= q_nxt;
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign q     = q_r;
    assign q_msb = q_r[WIDTH-1];
    assign q_lsb = q_r[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed testbench for universal_shift_register.
// Vector table for single steps, hand sequences for bursts.
module tb_universal_shift_register;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [2:0]       mode;
    logic             din_msb;
    logic             din_lsb;
    logic [WIDTH-1:0] par_in;
    logic             burst_start;
    logic [CNT_W-1:0] burst_len;
    logic [WIDTH-1:0] q;
    logic             q_msb;
    logic             q_lsb;
    logic             busy;
    logic             done;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0] md;
        logic       dm;
        logic       dl;
        logic [7:0] par;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[13];

    universal_shift_register #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .din_msb     (din_msb),
        .din_lsb     (din_lsb),
        .par_in      (par_in),
        .burst_start (burst_start),
        .burst_len   (burst_len),
        .q           (q),
        .q_msb       (q_msb),
        .q_lsb       (q_lsb),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] v);
        mode        = 3'd3;
        par_in      = v;
        burst_start = 1'b0;
        en          = 1'b1;
        tick();
        mode = 3'd0;
    endtask

    task automatic start_burst(input logic [2:0] m, input logic [3:0] len);
        mode        = m;
        burst_len   = len;
        burst_start = 1'b1;
        en          = 1'b1;
        tick();
        burst_start = 1'b0;
        mode        = 3'd0;
    endtask

    // Step until done is seen or the budget runs out.
    task automatic wait_done(input int max, output int cyc);
        cyc = 0;
        while (cyc < max) begin
            tick();
            cyc++;
            if (done) break;
        end
    endtask

    initial begin
        int cyc;
        int seen;

        vecs[0]  = '{3'd3, 1'b0, 1'b0, 8'hA5, 8'hA5, "load_a5"};
        vecs[1]  = '{3'd1, 1'b1, 1'b0, 8'h00, 8'hD2, "shr_d1"};
        vecs[2]  = '{3'd2, 1'b0, 1'b0, 8'h00, 8'hA4, "shl_d0"};
        vecs[3]  = '{3'd3, 1'b0, 1'b0, 8'h81, 8'h81, "load_81"};
        vecs[4]  = '{3'd4, 1'b0, 1'b0, 8'h00, 8'hC0, "ror"};
        vecs[5]  = '{3'd5, 1'b0, 1'b0, 8'h00, 8'h81, "rol"};
        vecs[6]  = '{3'd3, 1'b0, 1'b0, 8'h80, 8'h80, "load_80"};
        vecs[7]  = '{3'd6, 1'b0, 1'b1, 8'h00, 8'hC0, "asr"};
        vecs[8]  = '{3'd7, 1'b1, 1'b1, 8'hFF, 8'hC0, "rsvd"};
        vecs[9]  = '{3'd0, 1'b1, 1'b1, 8'hFF, 8'hC0, "hold"};
        vecs[10] = '{3'd1, 1'b0, 1'b1, 8'h00, 8'h60, "shr_d0"};
        vecs[11] = '{3'd3, 1'b0, 1'b0, 8'h3C, 8'h3C, "load_3c"};
        vecs[12] = '{3'd2, 1'b1, 1'b1, 8'h00, 8'h79, "shl_d1"};

        rst         = 1'b0;
        en          = 1'b0;
        mode        = 3'd0;
        din_msb     = 1'b0;
        din_lsb     = 1'b0;
        par_in      = '0;
        burst_start = 1'b0;
        burst_len   = '0;
        tick();

        // Reset from a nonzero register.
        load(8'hFF);
        check("pre_reset_q", q, 8'hFF);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_q", q, 8'h00);
        check("reset_msb", q_msb, 1'b0);
        check("reset_lsb", q_lsb, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);

        // Single-step table.
        for (int i = 0; i < 13; i++) begin
            mode    = vecs[i].md;
            din_msb = vecs[i].dm;
            din_lsb = vecs[i].dl;
            par_in  = vecs[i].par;
            en      = 1'b1;
            tick();
            check(vecs[i].name, q, vecs[i].exp);
            check({vecs[i].name, "_msb"}, q_msb, vecs[i].exp[7]);
            check({vecs[i].name, "_lsb"}, q_lsb, vecs[i].exp[0]);
            check({vecs[i].name, "_busy"}, busy, 1'b0);
        end

        // en low holds q and ignores burst_start.
        mode        = 3'd1;
        burst_start = 1'b1;
        burst_len   = 4'd2;
        en          = 1'b0;
        tick();
        tick();
        burst_start = 1'b0;
        check("en0_q", q, 8'h79);
        check("en0_busy", busy, 1'b0);

        // ROL burst of 3 with mode changes during the burst.
        load(8'h01);
        start_burst(3'd5, 4'd3);
        check("rol_b_start_q", q, 8'h01);
        check("rol_b_start_busy", busy, 1'b1);
        mode   = 3'd3;
        par_in = 8'hFF;
        tick();
        check("rol_b1_q", q, 8'h02);
        check("rol_b1_busy", busy, 1'b1);
        tick();
        check("rol_b2_q", q, 8'h04);
        check("rol_b2_busy", busy, 1'b1);
        check("rol_b2_done", done, 1'b0);
        mode = 3'd0;
        tick();
        check("rol_b3_q", q, 8'h08);
        check("rol_b3_busy", busy, 1'b0);
        check("rol_b3_done", done, 1'b1);
        tick();
        check("rol_after_done", done, 1'b0);
        check("rol_after_q", q, 8'h08);

        // SHL burst of 4 with two paused cycles.
        load(8'h00);
        din_lsb = 1'b1;
        start_burst(3'd2, 4'd4);
        tick();
        check("pause_s1", q, 8'h01);
        tick();
        check("pause_s2", q, 8'h03);
        en = 1'b0;
        tick();
        tick();
        check("pause_hold_q", q, 8'h03);
        check("pause_hold_busy", busy, 1'b1);
        check("pause_hold_done", done, 1'b0);
        en = 1'b1;
        tick();
        check("pause_s3", q, 8'h07);
        check("pause_s3_done", done, 1'b0);
        tick();
        check("pause_s4", q, 8'h0F);
        check("pause_s4_done", done, 1'b1);
        check("pause_s4_busy", busy, 1'b0);

        // Zero-length burst: immediate done, q unchanged.
        start_burst(3'd2, 4'd0);
        check("len0_q", q, 8'h0F);
        check("len0_busy", busy, 1'b0);
        check("len0_done", done, 1'b1);
        tick();
        check("len0_done_fall", done, 1'b0);

        // burst_start with LOAD runs LOAD normally.
        par_in = 8'h5A;
        start_burst(3'd3, 4'd3);
        check("load_bs_q", q, 8'h5A);
        check("load_bs_busy", busy, 1'b0);

        // Oversized burst length saturates at WIDTH.
        load(8'h01);
        start_burst(3'd5, 4'd12);
        wait_done(20, cyc);
        check("clamp_cycles", cyc, 8);
        check("clamp_q", q, 8'h01);

        // Reset on the second shift aborts without done.
        load(8'h00);
        din_lsb = 1'b1;
        start_burst(3'd2, 4'd5);
        tick();
        check("abort_s1", q, 8'h01);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_q", q, 8'h00);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || busy) seen++;
        end
        check("abort_no_done", seen, 0);
        check("abort_idle_q", q, 8'h00);
        start_burst(3'd2, 4'd2);
        check("restart_busy", busy, 1'b1);
        wait_done(10, cyc);
        check("restart_cycles", cyc, 2);
        check("restart_q", q, 8'h03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
